// File: rtl/neuron_mac_if.sv
// Handshake/data bundle between the pixel/weight readers, the neuron MAC and
// the activation stage.
interface neuron_mac_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int OUT_WIDTH  = 16
);
    logic                         start;
    logic signed [ACC_WIDTH-1:0]  bias;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] pixel;
    logic signed [DATA_WIDTH-1:0] weight;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         busy;

    modport master (
        output start, bias, in_valid, pixel, weight, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, bias, in_valid, pixel, weight, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one neuron: streams signed pixel/weight
// pairs, adds the bias, and hands one saturated pre-activation value onward.
module neuron_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int NUM_INPUTS = 784,
    parameter int OUT_WIDTH  = 16
) (
    input logic         clk,
    input logic         rst,
    neuron_mac_if.slave bus
);
    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_BIAS, S_OUT} state_e;

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    biased;

    function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        if (a > SAT_MAX)      return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (a < SAT_MIN) return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else                  return a[OUT_WIDTH-1:0];
    endfunction

    assign prod   = bus.pixel * bus.weight;
    assign biased = acc_q + bias_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        bias_d      = bias_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    count_d = '0;
                    bias_d  = bus.bias;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d   = acc_q + ACC_WIDTH'(prod);
                    count_d = count_q + 1'b1;
                    if (count_q == LAST) state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                // Result register is loaded here so it is stable for the whole OUT phase.
                acc_d       = biased;
                out_valid_d = 1'b1;
                out_data_d  = sat(biased);
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            bias_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with a 4-input neuron: basic sum, both
// saturation limits, stalls/backpressure, ignored inputs and mid-op reset.
module tb_neuron_mac;
    localparam int DW = 8, AW = 24, NI = 4, OW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    neuron_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

    neuron_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_INPUTS(NI), .OUT_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    int px[4];
    int wt[4];

    always @(posedge clk) if (!rst && bus.out_valid && bus.out_ready) hs_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One evaluation using px/wt; gap idle cycles between beats, ready_dly
    // cycles of backpressure, noise pokes start/bias while they must be ignored.
    task automatic run_eval(input string tag, input int b, input int gap,
                            input int ready_dly, input bit noise, input int exp);
        int hs0;
        hs0 = hs_cnt;
        bus.start = 1'b1;
        bus.bias  = AW'(b);
        tick();
        bus.start = 1'b0;
        bus.bias  = '0;
        chk({tag, ".busy"}, bus.busy, 1);
        chk({tag, ".in_ready"}, bus.in_ready, 1);
        for (int i = 0; i < NI; i++) begin
            bus.in_valid = 1'b1;
            bus.pixel    = DW'(px[i]);
            bus.weight   = DW'(wt[i]);
            tick();
            bus.in_valid = 1'b0;
            if (i != NI - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (noise) begin
                        bus.start = 1'b1;
                        bus.bias  = AW'(999);
                    end
                    tick();
                    bus.start = 1'b0;
                    bus.bias  = '0;
                end
            end
        end
        chk({tag, ".bias_valid"}, bus.out_valid, 0);
        chk({tag, ".bias_ready"}, bus.in_ready, 0);
        tick();
        chk({tag, ".out_valid"}, bus.out_valid, 1);
        chk({tag, ".out_data"}, bus.out_data, exp);
        for (int d = 0; d < ready_dly; d++) begin
            if (noise) bus.start = 1'b1;
            tick();
            chk({tag, ".hold_valid"}, bus.out_valid, 1);
            chk({tag, ".hold_data"}, bus.out_data, exp);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, ".idle_valid"}, bus.out_valid, 0);
        chk({tag, ".idle_data"}, bus.out_data, 0);
        chk({tag, ".idle_busy"}, bus.busy, 0);
        chk({tag, ".handshakes"}, hs_cnt - hs0, 1);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.pixel     = '0;
        bus.weight    = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst.out_valid", bus.out_valid, 0);
        chk("rst.out_data", bus.out_data, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.in_ready", bus.in_ready, 0);
        rst = 1'b0;
        tick();

        // 1*10 + 2*(-1) + 3*2 + 4*3 + 4 = 30, then an immediate second run
        px = '{1, 2, 3, 4};
        wt = '{10, -1, 2, 3};
        run_eval("basic", 4, 0, 0, 1'b0, 30);
        run_eval("b2b", 4, 0, 0, 1'b0, 30);

        // 4*127*127 = 64516 -> clamps high
        px = '{127, 127, 127, 127};
        wt = '{127, 127, 127, 127};
        run_eval("possat", 0, 0, 0, 1'b0, 32767);

        // 4*(-128*127) - 1 = -65025 -> clamps low
        px = '{-128, -128, -128, -128};
        wt = '{127, 127, 127, 127};
        run_eval("negsat", -1, 0, 0, 1'b0, -32768);

        px = '{1, 2, 3, 4};
        wt = '{10, -1, 2, 3};
        run_eval("stall", 4, 3, 5, 1'b0, 30);

        // Pairs offered while idle must not be consumed
        bus.in_valid = 1'b1;
        bus.pixel    = DW'(100);
        bus.weight   = DW'(100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.in_ready", bus.in_ready, 0);
            chk("idle.busy", bus.busy, 0);
        end
        bus.in_valid = 1'b0;
        run_eval("ignore", 4, 2, 3, 1'b1, 30);

        // Reset after two beats drops the partial sum
        bus.start = 1'b1;
        bus.bias  = AW'(50);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.pixel    = DW'(px[i]);
            bus.weight   = DW'(wt[i]);
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst.out_valid", bus.out_valid, 0);
        chk("midrst.out_data", bus.out_data, 0);
        chk("midrst.busy", bus.busy, 0);
        chk("midrst.in_ready", bus.in_ready, 0);
        run_eval("after_rst", 4, 0, 0, 1'b0, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
